// File: rtl/axis_ready_skid_ctrl.sv
// Registered-ready front end for the 40G-to-MII write path. Accepted beats land in a
// small circular skid buffer and drain into the CDC FIFO whenever it can take them.
module axis_ready_skid_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_aresetn,
    input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]                 s_axis_tkeep,
    input  logic                                  s_axis_tlast,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    output logic [DATA_WIDTH+KEEP_WIDTH:0]        fifo_din,
    output logic                                  fifo_wr_en,
    input  logic                                  full_flag,
    input  logic                                  wr_rst_busy,
    output logic [$clog2(SKID_DEPTH+1)-1:0]       skid_level,
    output logic [CNT_WIDTH-1:0]                  stall_cnt,
    output logic [CNT_WIDTH-1:0]                  frame_cnt
);

    localparam int LVL_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int ENT_W = DATA_WIDTH + KEEP_WIDTH + 1;

    logic [ENT_W-1:0] skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;
    logic             tready_q;
    logic             accept;
    logic             drain;
    logic [LVL_W:0]   count_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes: a beat moves on the input when tvalid & tready at the clock edge, and on
    // the FIFO side on every cycle fifo_wr_en is high; tvalid never depends on tready.
    always_comb begin
        accept     = s_axis_tvalid & tready_q;
        drain      = axis_aresetn & (level != '0) & ~full_flag & ~wr_rst_busy;
        count_next = {1'b0, level} + (LVL_W+1)'(accept) - (LVL_W+1)'(drain);
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            tready_q  <= 1'b0;
            stall_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (drain) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            level <= count_next[LVL_W-1:0];
            // Ready looks one beat ahead so the beat accepted while it falls still fits.
            tready_q <= ~wr_rst_busy & (count_next < (LVL_W+1)'(SKID_DEPTH));
            if (s_axis_tvalid & ~tready_q & ~(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (accept & s_axis_tlast) begin
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_aresetn && accept) begin
            skid_mem[wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_aresetn && accept) begin
            assert (level != LVL_W'(SKID_DEPTH));
        end
    end

    assign s_axis_tready = tready_q;
    assign fifo_wr_en    = drain;
    assign fifo_din      = skid_mem[rd_ptr];
    assign skid_level    = level;

endmodule

// File: tb/tb_axis_ready_skid_ctrl.sv
// Bench for axis_ready_skid_ctrl: queue-based skid model checked every cycle, an
// end-to-end stream scoreboard, and literal checks on the called-out boundaries.
module tb_axis_ready_skid_ctrl;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DEPTH = 2;
    localparam int CW    = 8;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int EW    = DW + KW + 1;

    // clock / reset
    logic axis_aclk    = 1'b0;
    logic axis_aresetn = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    logic [DW-1:0] s_axis_tdata  = '0;
    logic [KW-1:0] s_axis_tkeep  = '0;
    logic          s_axis_tlast  = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [EW-1:0] fifo_din;
    logic          fifo_wr_en;
    logic          full_flag     = 1'b0;
    logic          wr_rst_busy   = 1'b0;
    logic [LW-1:0] skid_level;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] frame_cnt;

    axis_ready_skid_ctrl #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .SKID_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .axis_aclk     (axis_aclk),
        .axis_aresetn  (axis_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .fifo_din      (fifo_din),
        .fifo_wr_en    (fifo_wr_en),
        .full_flag     (full_flag),
        .wr_rst_busy   (wr_rst_busy),
        .skid_level    (skid_level),
        .stall_cnt     (stall_cnt),
        .frame_cnt     (frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model state: exp_q holds the beats the skid must contain, oldest first
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] sent_q[$];
    logic [EW-1:0] got_q[$];
    logic          m_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_frame = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: check outputs mid-cycle, then advance the model across the next edge
    always @(negedge axis_aclk) begin : cmp_proc
        logic acc;
        logic drn;
        drn = axis_aresetn && (exp_q.size() != 0) && !full_flag && !wr_rst_busy;
        if (m_valid) begin
            check("tready", 64'(s_axis_tready), 64'(m_ready));
            check("skid_level", 64'(skid_level), 64'(exp_q.size()));
            check("fifo_wr_en", 64'(fifo_wr_en), 64'(drn));
            if (exp_q.size() != 0) check("fifo_din", 64'(fifo_din), 64'(exp_q[0]));
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            check("frame_cnt", 64'(frame_cnt), 64'(m_frame));
        end
        if (fifo_wr_en === 1'b1) got_q.push_back(fifo_din);
        if (!axis_aresetn) begin
            exp_q.delete();
            m_ready = 1'b0;
            m_stall = '0;
            m_frame = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            acc = s_axis_tvalid && m_ready;
            if (s_axis_tvalid && !m_ready && m_stall != '1) m_stall++;
            if (acc && s_axis_tlast) m_frame++;
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
            m_ready = !wr_rst_busy && (exp_q.size() < DEPTH);
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge axis_aclk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        int   waited = 0;
        logic hs     = 1'b0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge axis_aclk);
            hs = s_axis_tready;
            @(posedge axis_aclk);
            #1;
            waited++;
        end while (!hs && waited < 1000);
        check("handshake", 64'(hs), 64'(1));
        if (hs) sent_q.push_back({l, k, d});
        s_axis_tvalid = 1'b0;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 64'(got_q.size()), 64'(sent_q.size()));
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
            check({tag, "_beat"}, 64'(got_q[i]), 64'(sent_q[i]));
        got_q.delete();
        sent_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    int             len_t[5]  = '{3, 1, 7, 2, 5};
    int             gap_t[5]  = '{0, 2, 1, 3, 0};
    logic [KW-1:0]  keep_t[5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0011};

    initial begin
        // reset then idle
        repeat (3) @(posedge axis_aclk);
        #1;
        check("rst_tready", 64'(s_axis_tready), 64'(0));
        check("rst_level", 64'(skid_level), 64'(0));
        check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        check("rst_stall", 64'(stall_cnt), 64'(0));
        check("rst_frame", 64'(frame_cnt), 64'(0));
        axis_aresetn = 1'b1;
        @(negedge axis_aclk);
        check("release_tready_0", 64'(s_axis_tready), 64'(0));
        idle(1);
        check("release_tready_1", 64'(s_axis_tready), 64'(1));
        idle(2);

        // full-rate stream
        for (int i = 0; i < 64; i++) send_beat(32'h1000_0000 + i, 4'hF, 1'b0);
        idle(3);
        check("full_rate_writes", 64'(got_q.size()), 64'(64));
        check("full_rate_stall", 64'(stall_cnt), 64'(0));
        compare_stream("full_rate");

        // FIFO full for 10 cycles mid-stream
        fork
            for (int i = 0; i < 30; i++) send_beat(32'h2000_0000 + i, 4'hF, 1'b0);
            begin
                repeat (8) @(posedge axis_aclk);
                #1 full_flag = 1'b1;
                repeat (10) @(posedge axis_aclk);
                #1 full_flag = 1'b0;
            end
        join
        idle(4);
        check("full_stall_cnt", 64'(stall_cnt), 64'(10));
        compare_stream("full_pulse");

        // wr_rst_busy with one entry held
        full_flag = 1'b1;
        send_beat(32'h3000_00AA, 4'b0110, 1'b0);
        check("busy_pre_level", 64'(skid_level), 64'(1));
        wr_rst_busy = 1'b1;
        full_flag   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge axis_aclk);
            check("busy_wr_en", 64'(fifo_wr_en), 64'(0));
            check("busy_level", 64'(skid_level), 64'(1));
        end
        idle(1);
        wr_rst_busy = 1'b0;
        @(negedge axis_aclk);
        check("busy_clear_wr_en", 64'(fifo_wr_en), 64'(1));
        check("busy_clear_tready", 64'(s_axis_tready), 64'(0));
        idle(1);
        check("busy_recover_tready", 64'(s_axis_tready), 64'(1));
        check("busy_recover_level", 64'(skid_level), 64'(0));
        compare_stream("busy");

        // five frames with gaps and intermittent FIFO full
        fork
            for (int f = 0; f < 5; f++) begin
                for (int b = 0; b < len_t[f]; b++) begin
                    send_beat(32'h5000_0000 | (f << 8) | b,
                              (b == len_t[f] - 1) ? keep_t[f] : 4'hF,
                              b == len_t[f] - 1);
                    if (b % 3 == 2) idle(1);
                end
                if (gap_t[f] > 0) idle(gap_t[f]);
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    full_flag = (c % 7) < 2;
                    idle(1);
                end
                full_flag = 1'b0;
            end
        join
        idle(6);
        check("frames_cnt", 64'(frame_cnt), 64'(5));
        compare_stream("frames");

        // reset with two beats in the skid
        full_flag = 1'b1;
        send_beat(32'h6000_0001, 4'hF, 1'b1);
        send_beat(32'h6000_0002, 4'hF, 1'b1);
        check("rst_pre_level", 64'(skid_level), 64'(2));
        axis_aresetn = 1'b0;
        full_flag    = 1'b0;
        @(negedge axis_aclk);
        check("rst_mid_wr_en", 64'(fifo_wr_en), 64'(0));
        idle(1);
        check("rst_post_level", 64'(skid_level), 64'(0));
        check("rst_post_tready", 64'(s_axis_tready), 64'(0));
        check("rst_post_wr_en", 64'(fifo_wr_en), 64'(0));
        check("rst_post_frame", 64'(frame_cnt), 64'(0));
        axis_aresetn = 1'b1;
        idle(4);
        check("rst_discarded", 64'(got_q.size()), 64'(0));
        got_q.delete();
        sent_q.delete();

        // frame counter wrap: 257 single-beat frames
        for (int i = 0; i < 257; i++) send_beat(32'h7000_0000 + i, 4'hF, 1'b1);
        idle(3);
        check("frame_wrap", 64'(frame_cnt), 64'(1));
        compare_stream("wrap");

        // stall counter saturation
        full_flag = 1'b1;
        fork
            for (int i = 0; i < 4; i++) send_beat(32'h8000_0000 + i, 4'hF, 1'b0);
            begin
                idle(300);
                check("stall_saturate", 64'(stall_cnt), 64'(8'hFF));
                full_flag = 1'b0;
            end
        join
        idle(4);
        check("stall_held", 64'(stall_cnt), 64'(8'hFF));
        compare_stream("saturate");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
